// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word request at a time and
// presents each fetched word to the CPU, applying redirects when it is taken.
`timescale 1ns/1ps
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jump_reg_addr,
    output logic        err_misaligned_pc,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        err_q, err_d;
    logic [31:0] seq_pc;
    logic [31:0] br_tgt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            ipc_q   <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            err_q   <= err_d;
        end
    end

    // Handshake: instr_valid stays high with instruction/instr_pc frozen until a
    // cycle with instr_valid & instr_ready; redirect inputs are honoured only then.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        err_d   = err_q;
        seq_pc  = ipc_q + 32'd4;
        br_tgt  = seq_pc + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        case (state_q)
            IDLE: begin
                if (enable) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + 32'd4;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    state_d = enable ? FETCH : IDLE;
                    pc_d    = seq_pc;
                    if (jump_reg) begin
                        // A misaligned jr target is fatal until reset.
                        if (jump_reg_addr[1:0] != 2'b00) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            pc_d = jump_reg_addr;
                        end
                    end else if (jump) begin
                        pc_d = {seq_pc[31:28], jump_target, 2'b00};
                    end else if (branch_taken) begin
                        pc_d = br_tgt;
                    end
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    assign imem_req          = (state_q == FETCH);
    assign imem_addr         = imem_req ? pc_q : 32'h0;
    assign instr_valid       = (state_q == HOLD);
    assign instruction       = instr_q;
    assign instr_pc          = ipc_q;
    assign err_misaligned_pc = err_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model with programmable ack latency,
// scoreboard of expected fetch addresses and delivered instructions.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] jump_reg_addr;
    logic        err_misaligned_pc;
    logic [1:0]  dbg_state;

    // second instance for the PC wrap case
    logic        w_rst_n;
    logic        w_en;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_ipc;
    logic        w_valid;
    logic        w_err;
    logic [1:0]  w_state;

    int          ack_lat;
    int          wait_cnt;
    logic        force_ack;
    int          n_cmp;
    int          n_err;
    logic [31:0] addr_exp_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_ack   = (imem_req && (wait_cnt >= ack_lat)) || force_ack;
    assign imem_rdata = mem_word(imem_addr);

    always_ff @(posedge clock) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instruction(instruction), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target), .jump_reg(jump_reg),
        .jump_reg_addr(jump_reg_addr), .err_misaligned_pc(err_misaligned_pc),
        .dbg_state_o(dbg_state)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clock(clock), .reset_n(w_rst_n), .enable(w_en),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req),
        .imem_rdata(mem_word(w_addr)), .instruction(w_instr), .instr_pc(w_ipc),
        .instr_valid(w_valid), .instr_ready(1'b1),
        .branch_taken(1'b0), .branch_offset(16'h0), .jump(1'b0),
        .jump_target(26'h0), .jump_reg(1'b0), .jump_reg_addr(32'h0),
        .err_misaligned_pc(w_err), .dbg_state_o(w_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Request monitor: every accepted request must be one the test expects.
    always @(negedge clock) begin
        if (reset_n && imem_req && imem_ack) begin
            check("req_expected", 32'(addr_exp_q.size() != 0), 32'd1);
            if (addr_exp_q.size() != 0) begin
                logic [31:0] a;
                a = addr_exp_q.pop_front();
                check("imem_addr", imem_addr, a);
                exp_pc_q.push_back(a);
                exp_q.push_back(mem_word(a));
            end
        end
    end

    // Consume monitor: delivered instruction must match the scoreboard.
    always @(negedge clock) begin
        if (reset_n && instr_valid && instr_ready) begin
            check("instr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("instr_pc", instr_pc, exp_pc_q.pop_front());
                check("instruction", instruction, exp_q.pop_front());
            end
        end
    end

    task automatic clear_redirect();
        branch_taken  = 1'b0;
        branch_offset = 16'h0;
        jump          = 1'b0;
        jump_target   = 26'h0;
        jump_reg      = 1'b0;
        jump_reg_addr = 32'h0;
    endtask

    // Fetch one instruction from exp_addr, stall `hold` cycles in HOLD (optionally
    // with redirect noise), then consume it with the given redirect.
    task automatic fetch_one(input logic [31:0] exp_addr, input int lat, input int hold,
                             input logic noise, input logic jr, input logic [31:0] jra,
                             input logic j, input logic [25:0] jt, input logic br,
                             input logic [15:0] bo, input logic en_after);
        ack_lat = lat;
        addr_exp_q.push_back(exp_addr);
        enable      = 1'b1;
        instr_ready = 1'b0;
        clear_redirect();
        for (int n = 0; n < 40 && !instr_valid; n++) begin
            if (imem_req) check("req_addr_stable", imem_addr, exp_addr);
            tick();
        end
        check("valid_seen", 32'(instr_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            if (noise) begin
                branch_taken  = 1'b1;
                branch_offset = 16'h0040;
                jump          = 1'b1;
                jump_target   = 26'h123_4567;
                jump_reg      = 1'b1;
                jump_reg_addr = 32'h0000_0202;
            end
            check("hold_no_req", 32'(imem_req), 32'd0);
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_pc", instr_pc, exp_addr);
            check("hold_instr", instruction, mem_word(exp_addr));
            check("hold_no_err", 32'(err_misaligned_pc), 32'd0);
            tick();
        end
        jump_reg      = jr;
        jump_reg_addr = jra;
        jump          = j;
        jump_target   = jt;
        branch_taken  = br;
        branch_offset = bo;
        instr_ready   = 1'b1;
        enable        = en_after;
        tick();
        instr_ready = 1'b0;
        clear_redirect();
        check("valid_dropped", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_addr[2];
        int          wrap_n;
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        w_rst_n = 1'b0;
        w_en = 1'b0;
        enable = 1'b1;
        instr_ready = 1'b0;
        force_ack = 1'b0;
        ack_lat = 0;
        clear_redirect();
        tick();
        tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_ipc", instr_pc, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_err", 32'(err_misaligned_pc), 32'd0);

        // Zero-latency memory, consumer always ready: one instruction per 2 cycles.
        reset_n = 1'b1;
        instr_ready = 1'b1;
        addr_exp_q.push_back(32'h0);
        addr_exp_q.push_back(32'h4);
        addr_exp_q.push_back(32'h8);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("alt_req", 32'(imem_req), 32'((i % 2) == 0));
            check("alt_valid", 32'(instr_valid), 32'(i % 2));
            if (i == 4) enable = 1'b0;
        end
        tick();
        check("idle_no_req", 32'(imem_req), 32'd0);
        check("idle_state", 32'(dbg_state), 32'd0);
        instr_ready = 1'b0;

        // Slow memory and consumer backpressure.
        fetch_one(32'h0000_000C, 2, 3, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0);
        check("en0_idle", 32'(dbg_state), 32'd0);
        check("en0_no_req", 32'(imem_req), 32'd0);

        // Redirects: jr, branches, ignored noise, jump, priority.
        fetch_one(32'h0000_0010, 1, 0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
        fetch_one(32'h0000_0100, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'hFFFF, 1'b1);
        fetch_one(32'h0000_0100, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'h0004, 1'b1);
        fetch_one(32'h0000_0114, 0, 3, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
        fetch_one(32'h0000_0118, 0, 0, 1'b0, 1'b1, 32'h1000_0040, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
        fetch_one(32'h1000_0040, 0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h000_0010, 1'b0, 16'h0, 1'b1);
        fetch_one(32'h1000_0040, 0, 1, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 26'h000_0010, 1'b1, 16'h0005, 1'b1);
        fetch_one(32'h0000_0200, 0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h3FF_FFFF, 1'b0, 16'h0, 1'b1);
        fetch_one(32'h0FFF_FFFC, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 16'h8000, 1'b1);

        // Misaligned jr halts until reset.
        fetch_one(32'h0FFE_0000, $urandom_range(0, 3), 0, 1'b0, 1'b1, 32'h0000_0202, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("halt_err", 32'(err_misaligned_pc), 32'd1);
            check("halt_no_req", 32'(imem_req), 32'd0);
            check("halt_state", 32'(dbg_state), 32'd3);
            tick();
        end
        reset_n = 1'b0;
        #1;
        check("rst2_err", 32'(err_misaligned_pc), 32'd0);
        check("rst2_state", 32'(dbg_state), 32'd0);
        tick();
        reset_n = 1'b1;
        enable = 1'b0;
        fetch_one(32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0);

        // Reset while a request is outstanding; a late ack must be ignored.
        ack_lat = 5;
        enable = 1'b1;
        tick();
        tick();
        check("pend_req", 32'(imem_req), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_req_drop", 32'(imem_req), 32'd0);
        check("async_valid", 32'(instr_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        check("late_ack_ignored", 32'(instr_valid), 32'd0);
        check("restart_state", 32'(dbg_state), 32'd1);
        check("restart_addr", imem_addr, 32'h0);
        fetch_one(32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0);

        // PC wrap at the top of the address space.
        w_rst_n = 1'b1;
        w_en = 1'b1;
        wrap_n = 0;
        for (int i = 0; i < 20 && wrap_n < 2; i++) begin
            tick();
            if (w_req) begin
                wrap_addr[wrap_n] = w_addr;
                wrap_n++;
            end
        end
        check("wrap_count", 32'(wrap_n), 32'd2);
        if (wrap_n == 2) begin
            check("wrap_first", wrap_addr[0], 32'hFFFF_FFFC);
            check("wrap_second", wrap_addr[1], 32'h0000_0000);
        end

        tick();
        check("addr_q_drained", 32'(addr_exp_q.size()), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream instruction-fetch stage feeding the `mips_cpu` `instruction` input.
- Owns the program counter and issues one word request at a time to instruction memory.
- Presents each fetched word with a valid/ready handshake.
- Accepts branch, jump and jump-register redirects from the consumer when it takes an instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  reset; asynchronous, active-low
enable  input  1  permits new fetch requests
imem_req  output  1  instruction memory request
imem_addr  output  32  word address of request (byte address, [1:0]=0)
imem_ack  input  1  memory response valid; may assert in same cycle as imem_req
imem_rdata  input  32  instruction word, valid with imem_ack
instruction  output  32  fetched instruction to CPU
instr_pc  output  32  PC of presented instruction
instr_valid  output  1  instruction/instr_pc valid
instr_ready  input  1  consumer takes instruction this cycle
branch_taken  input  1  redirect: PC-relative branch
branch_offset  input  16  branch immediate (words)
jump  input  1  redirect: j/jal
jump_target  input  26  jump field
jump_reg  input  1  redirect: jr
jump_reg_addr  input  32  jr target
err_misaligned_pc  output  1  sticky: jr target not word-aligned

Behaviour:
- Reset (async, while reset_n=0): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0, instruction=0, instr_pc=0, instr_valid=0, err_misaligned_pc=0. Any outstanding request is abandoned; a late imem_ack is ignored.
- States: IDLE, FETCH, HOLD, HALT.
- IDLE: outputs quiet. If enable=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc, both stable until imem_ack.
  - On imem_ack (registered at that edge): instruction<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, go to HOLD.
  - imem_req is 0 in the cycle after the ack.
  - enable dropping mid-FETCH does not cancel the request.
- HOLD:
  - instr_valid=1; instruction and instr_pc held stable until consumed.
  - Consume = instr_valid & instr_ready. On consume: instr_valid<=0, then apply redirect (below).
  - Next state after consume: FETCH if enable=1, else IDLE.
- Redirect inputs are sampled only on the consume cycle and ignored otherwise.
  - Priority: jump_reg > jump > branch_taken.
  - jump_reg: pc<=jump_reg_addr.
  - jump: pc<={instr_pc+4 [31:28], jump_target, 2'b00}.
  - branch_taken: pc<=instr_pc+4+(sign_extend(branch_offset)<<2).
  - No redirect: pc keeps instr_pc+4.
- Arithmetic: all PC math is 32-bit modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).
- Misalignment: if jump_reg wins and jump_reg_addr[1:0]!=0, set err_misaligned_pc<=1, go to HALT. HALT issues no requests, instr_valid=0, and is left only by reset.
- Throughput: with zero-latency ack, one instruction per 2 cycles (req N, valid N+1, consume N+1, req N+2).
- Memory wait of k cycles adds k cycles per instruction.
- Backpressure adds cycles without losing or duplicating instructions.

Test Plan:
- Reset, enable=1, ack same cycle, ready=1: imem_addr sequence 0x0,0x4,0x8; instr_pc matches each; instruction equals imem_rdata; instr_valid every other cycle.
- Ack delayed 2 cycles with ready held 0 for 3 cycles in HOLD: imem_req/imem_addr held stable while waiting; instruction/instr_pc stable in HOLD; no new request until consume; exactly one request per instruction.
- Branches at instr_pc=0x100:
  - branch_offset=0xFFFF, taken on consume: next imem_addr=0x100.
  - branch_offset=0x0004: next imem_addr=0x114.
  - branch_taken asserted while ready=0: no effect.
- Redirect priority at instr_pc=0x1000_0040:
  - jump=1, jump_target=0x000_0010: next imem_addr=0x1000_0040.
  - jump, jump_reg (addr 0x200) and branch all asserted: next imem_addr=0x200.
- Error and wrap:
  - jump_reg_addr=0x202 on consume: err_misaligned_pc=1, no further imem_req until reset_n pulse, then fetch resumes at RESET_PC.
  - RESET_PC=0xFFFF_FFFC: second fetch address is 0x0.
- Control edges:
  - reset_n low mid-FETCH with ack pending: imem_req and instr_valid drop immediately; an ack after release is ignored; fetch restarts at RESET_PC.
  - enable=0 in HOLD: after consume, state goes to IDLE with no request.
